// File: rtl/cam_pixel_capture_pkg.sv
// Shared pixel-stream definitions: RGB565 layout, capture FSM states, default frame geometry.
package cam_pixel_capture_pkg;

  localparam int unsigned PixW     = 16;
  localparam int unsigned RedW     = 5;
  localparam int unsigned GreenW   = 6;
  localparam int unsigned BlueW    = 5;
  localparam int unsigned RedOfs   = 11;
  localparam int unsigned GreenOfs = 5;
  localparam int unsigned BlueOfs  = 0;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VActiveDef = 480;

  typedef enum logic [1:0] {
    StIdle,
    StVblank,
    StActive,
    StSkip
  } cap_state_e;

  // Combine two camera bytes into one RGB565 word in the configured byte order.
  function automatic logic [PixW-1:0] pack_pixel(input logic [7:0] first,
                                                 input logic [7:0] second,
                                                 input logic       hi_first);
    return hi_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera byte bus in, RGB565 pixel stream out; master is the capture block, slave its environment.
interface cam_pixel_capture_if
  import cam_pixel_capture_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic            cam_pclk_en;
  logic            cam_vsync;
  logic            cam_href;
  logic [7:0]      cam_data;
  logic [PixW-1:0] pixel_out;
  logic            data_valid_out;
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_out;
  logic            frame_start;
  logic            line_end;
  logic            frame_done;

  modport master (
    input  cam_pclk_en, cam_vsync, cam_href, cam_data,
    output pixel_out, data_valid_out, x_out, y_out, frame_start, line_end, frame_done
  );

  modport slave (
    output cam_pclk_en, cam_vsync, cam_href, cam_data,
    input  pixel_out, data_valid_out, x_out, y_out, frame_start, line_end, frame_done
  );
endinterface

// File: rtl/cam_sync_edge.sv
// Rise/fall detector whose history only advances on qualified (strobed) samples.
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else if (strobe) begin
      prev_q <= sig;
    end
  end

  assign rise = strobe & sig & ~prev_q;
  assign fall = strobe & ~sig & prev_q;
endmodule

// File: rtl/cam_pixel_capture.sv
// Camera byte-pair capture into RGB565 pixels with x/y tagging, geometry checks and frame counting.
module cam_pixel_capture
  import cam_pixel_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter bit          HI_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  cam_pixel_capture_if.master bus,
  input  logic                capture_en,
  input  logic                err_clr,
  output logic                line_err,
  output logic                frame_err,
  output logic [15:0]         frame_count
);
  localparam int unsigned XW  = $clog2(H_ACTIVE);
  localparam int unsigned YW  = $clog2(V_ACTIVE);
  // Counters need one extra value so a complete line/frame can be told apart from an overrun.
  localparam int unsigned XCW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YCW = $clog2(V_ACTIVE + 1);
  localparam logic [XCW-1:0] XMax = XCW'(H_ACTIVE);
  localparam logic [YCW-1:0] YMax = YCW'(V_ACTIVE);

  cap_state_e      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            phase_q, phase_d;
  logic [XCW-1:0]  x_q, x_d;
  logic [YCW-1:0]  y_q, y_d;
  logic            line_err_q, line_err_d;
  logic            frame_err_q, frame_err_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            valid_q, valid_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [XW-1:0]   xo_q, xo_d;
  logic [YW-1:0]   yo_q, yo_d;
  logic            fs_q, fs_d;
  logic            le_q, le_d;
  logic            fd_q, fd_d;

  logic vsync_rise, vsync_fall, href_rise, href_fall;
  logic line_set, frame_set, line_end_ev;

  cam_sync_edge u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (bus.cam_pclk_en),
    .sig    (bus.cam_vsync),
    .rise   (vsync_rise),
    .fall   (vsync_fall)
  );

  cam_sync_edge u_href_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (bus.cam_pclk_en),
    .sig    (bus.cam_href),
    .rise   (href_rise),
    .fall   (href_fall)
  );

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    phase_d     = phase_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    line_set    = 1'b0;
    frame_set   = 1'b0;
    valid_d     = 1'b0;
    pix_d       = pix_q;
    xo_d        = xo_q;
    yo_d        = yo_q;
    fs_d        = 1'b0;
    le_d        = 1'b0;
    fd_d        = 1'b0;
    // An href still high when vsync rises closes the line on that same strobe.
    line_end_ev = href_fall | (vsync_rise & bus.cam_href);

    unique case (state_q)
      StIdle: begin
        if (vsync_rise) state_d = StVblank;
      end
      StVblank: begin
        if (vsync_fall) begin
          state_d = capture_en ? StActive : StSkip;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end
      StSkip: begin
        if (vsync_rise) state_d = StVblank;
      end
      StActive: begin
        if (bus.cam_pclk_en && bus.cam_href) begin
          // A fresh href always starts on the first byte of a pair.
          if (phase_q && !href_rise) begin
            phase_d = 1'b0;
            if (x_q < XMax && y_q < YMax) begin
              valid_d = 1'b1;
              pix_d   = pack_pixel(byte_q, bus.cam_data, HI_FIRST);
              xo_d    = x_q[XW-1:0];
              yo_d    = y_q[YW-1:0];
              fs_d    = (x_q == '0) && (y_q == '0);
              le_d    = (x_q == XMax - 1'b1);
            end
            if (x_q >= XMax) line_set = 1'b1;
            else             x_d = x_q + 1'b1;
            if (y_q >= YMax) frame_set = 1'b1;
          end else begin
            byte_d  = bus.cam_data;
            phase_d = 1'b1;
          end
        end

        if (line_end_ev) begin
          if (x_d != XMax || phase_d) line_set = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q < YMax) y_d = y_q + 1'b1;
        end

        if (vsync_rise) begin
          state_d     = StVblank;
          fd_d        = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (y_d != YMax) frame_set = 1'b1;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    line_err_d  = err_clr ? 1'b0 : (line_err_q | line_set);
    frame_err_d = err_clr ? 1'b0 : (frame_err_q | frame_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      byte_q      <= '0;
      phase_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      pix_q       <= '0;
      xo_q        <= '0;
      yo_q        <= '0;
      fs_q        <= 1'b0;
      le_q        <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      phase_q     <= phase_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      pix_q       <= pix_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      fs_q        <= fs_d;
      le_q        <= le_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.pixel_out      = pix_q;
  assign bus.data_valid_out = valid_q;
  assign bus.x_out          = xo_q;
  assign bus.y_out          = yo_q;
  assign bus.frame_start    = fs_q;
  assign bus.line_end       = le_q;
  assign bus.frame_done     = fd_q;
  assign line_err           = line_err_q;
  assign frame_err          = frame_err_q;
  assign frame_count        = frame_cnt_q;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench: 4x2 frame geometry, strobe every other clock, both byte orders side by side.
module tb_cam_pixel_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pclk_en = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        capture_en = 1'b1, err_clr = 1'b0;
  logic        line_err_a, frame_err_a, line_err_b, frame_err_b;
  logic [15:0] fcnt_a, fcnt_b;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned pix_cnt = 0, fd_cnt = 0, p0 = 0, f0 = 0;

  cam_pixel_capture_if #(.XW(2), .YW(1)) bus_a ();
  cam_pixel_capture_if #(.XW(2), .YW(1)) bus_b ();

  assign bus_a.cam_pclk_en = pclk_en;
  assign bus_a.cam_vsync   = vsync;
  assign bus_a.cam_href    = href;
  assign bus_a.cam_data    = data;
  assign bus_b.cam_pclk_en = pclk_en;
  assign bus_b.cam_vsync   = vsync;
  assign bus_b.cam_href    = href;
  assign bus_b.cam_data    = data;

  cam_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .HI_FIRST(1'b1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_a),
    .capture_en  (capture_en),
    .err_clr     (err_clr),
    .line_err    (line_err_a),
    .frame_err   (frame_err_a),
    .frame_count (fcnt_a)
  );

  cam_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .HI_FIRST(1'b0)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_b),
    .capture_en  (capture_en),
    .err_clr     (err_clr),
    .line_err    (line_err_b),
    .frame_err   (frame_err_b),
    .frame_count (fcnt_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_a.data_valid_out) pix_cnt++;
    if (bus_a.frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One qualified camera sample followed by one idle clock; outputs are visible on return.
  task automatic strobe(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk); #1;
    pclk_en = 1'b1; vsync = vs; href = hr; data = d;
    @(posedge clk); #1;
    pclk_en = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) strobe(1'b0, 1'b1, base + 8'(i));
    strobe(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [15:0] exp_pix;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", 32'(bus_a.data_valid_out), 0);
    check("rst pixel", 32'(bus_a.pixel_out), 0);
    check("rst frame_done", 32'(bus_a.frame_done), 0);
    check("rst frame_count", 32'(fcnt_a), 0);
    check("rst line_err", 32'(line_err_a), 0);
    check("rst frame_err", 32'(frame_err_b), 0);
    rst_n = 1'b1;

    // Frame 1: 2 lines x 8 bytes 0x00..0x0F
    strobe(1'b0, 1'b0, 8'h00);
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b0, 1'b0, 8'h00);
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 8; i++) begin
        b = 8'(ln * 8 + i);
        strobe(1'b0, 1'b1, b);
        if (i % 2 == 1) begin
          exp_pix = {b - 8'd1, b};
          check("f1 valid", 32'(bus_a.data_valid_out), 1);
          check("f1 pixel", 32'(bus_a.pixel_out), 32'(exp_pix));
          check("f1 x", 32'(bus_a.x_out), 32'(i / 2));
          check("f1 y", 32'(bus_a.y_out), 32'(ln));
          check("f1 frame_start", 32'(bus_a.frame_start), 32'(ln == 0 && i == 1));
          check("f1 line_end", 32'(bus_a.line_end), 32'(i == 7));
        end else begin
          check("f1 no valid on first byte", 32'(bus_a.data_valid_out), 0);
        end
      end
      strobe(1'b0, 1'b0, 8'h00);
      check("f1 line_err", 32'(line_err_a), 0);
    end
    strobe(1'b1, 1'b0, 8'h00);
    check("f1 frame_done", 32'(bus_a.frame_done), 1);
    check("f1 frame_count", 32'(fcnt_a), 1);
    check("f1 frame_err", 32'(frame_err_a), 0);
    check("f1 pixel count", pix_cnt, 8);
    strobe(1'b1, 1'b0, 8'h00);
    check("f1 frame_done one pulse", 32'(bus_a.frame_done), 0);

    // Frame 2: 7-byte line (odd byte dropped), byte order, err_clr, then a full line
    strobe(1'b0, 1'b0, 8'h00);
    p0 = pix_cnt;
    strobe(1'b0, 1'b1, 8'hAA);
    strobe(1'b0, 1'b1, 8'h55);
    check("hi_first=1 pixel", 32'(bus_a.pixel_out), 32'h0000_AA55);
    check("hi_first=0 pixel", 32'(bus_b.pixel_out), 32'h0000_55AA);
    check("hi_first=0 valid", 32'(bus_b.data_valid_out), 1);
    for (int d = 1; d <= 5; d++) begin
      strobe(1'b0, 1'b1, 8'(d));
      if (d == 4) begin
        check("odd line pixel 3", 32'(bus_a.pixel_out), 32'h0000_0304);
        check("odd line x 3", 32'(bus_a.x_out), 2);
      end
    end
    strobe(1'b0, 1'b0, 8'h00);
    check("odd line line_err", 32'(line_err_a), 1);
    check("odd line pixel count", pix_cnt - p0, 3);
    pulse_err_clr();
    check("err_clr line_err", 32'(line_err_a), 0);
    strobe(1'b0, 1'b1, 8'h20);
    strobe(1'b0, 1'b1, 8'h21);
    check("after odd pixel", 32'(bus_a.pixel_out), 32'h0000_2021);
    check("after odd x", 32'(bus_a.x_out), 0);
    check("after odd y", 32'(bus_a.y_out), 1);
    for (int d = 2; d < 8; d++) strobe(1'b0, 1'b1, 8'h20 + 8'(d));
    strobe(1'b0, 1'b0, 8'h00);
    check("full line line_err", 32'(line_err_a), 0);
    strobe(1'b1, 1'b0, 8'h00);
    check("f2 frame_count", 32'(fcnt_a), 2);
    check("f2 frame_err", 32'(frame_err_a), 0);

    // Frame 3: capture_en=0 at vsync fall -> skipped
    capture_en = 1'b0;
    strobe(1'b0, 1'b0, 8'h00);
    capture_en = 1'b1;
    p0 = pix_cnt;
    f0 = fd_cnt;
    send_line(8'h40, 8);
    send_line(8'h48, 8);
    strobe(1'b1, 1'b0, 8'h00);
    check("skip pixel count", pix_cnt - p0, 0);
    check("skip frame_done count", fd_cnt - f0, 0);
    check("skip frame_count", 32'(fcnt_a), 2);
    check("skip line_err", 32'(line_err_a), 0);
    check("skip frame_err", 32'(frame_err_a), 0);

    // Frame 4: three lines -> third suppressed, frame_err
    strobe(1'b0, 1'b0, 8'h00);
    p0 = pix_cnt;
    send_line(8'h50, 8);
    send_line(8'h58, 8);
    send_line(8'h60, 8);
    check("3 lines pixel count", pix_cnt - p0, 8);
    strobe(1'b1, 1'b0, 8'h00);
    check("3 lines frame_err", 32'(frame_err_a), 1);
    check("3 lines frame_count", 32'(fcnt_a), 3);
    pulse_err_clr();
    check("err_clr frame_err", 32'(frame_err_a), 0);

    // Reset mid-line, released while href still high
    strobe(1'b0, 1'b0, 8'h00);
    strobe(1'b0, 1'b1, 8'h70);
    strobe(1'b0, 1'b1, 8'h71);
    strobe(1'b0, 1'b1, 8'h72);
    #2 rst_n = 1'b0;
    #3;
    check("mid reset frame_count", 32'(fcnt_a), 0);
    check("mid reset valid", 32'(bus_a.data_valid_out), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    p0 = pix_cnt;
    f0 = fd_cnt;
    for (int d = 3; d < 8; d++) strobe(1'b0, 1'b1, 8'h70 + 8'(d));
    strobe(1'b0, 1'b0, 8'h00);
    send_line(8'h78, 8);
    check("post reset no pixels", pix_cnt - p0, 0);
    strobe(1'b1, 1'b0, 8'h00);
    check("post reset no frame_done", fd_cnt - f0, 0);
    strobe(1'b0, 1'b0, 8'h00);
    send_line(8'h80, 8);
    send_line(8'h88, 8);
    strobe(1'b1, 1'b0, 8'h00);
    check("clean frame pixel count", pix_cnt - p0, 8);
    check("clean frame_done", 32'(bus_a.frame_done), 1);
    check("clean frame_count", 32'(fcnt_a), 1);
    check("clean line_err", 32'(line_err_a), 0);
    check("clean frame_err", 32'(frame_err_a), 0);
    check("clean frame_count b", 32'(fcnt_b), 1);
    check("clean line_err b", 32'(line_err_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
